// File: rtl/demux16_collector_if.sv
// Bit-serial producer / word consumer bundle for the 1-to-16 collector.
// The master side produces tagged bits and consumes words; the slave side is the collector.
interface demux16_collector_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             in_bit;
  logic [SEL_W-1:0] in_sel;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] fill_mask;
  logic             dup_err;

  modport master (
    output in_bit, in_sel, in_valid, clear, out_ready,
    input  in_ready, out_word, out_valid, fill_mask, dup_err
  );

  modport slave (
    input  in_bit, in_sel, in_valid, clear, out_ready,
    output in_ready, out_word, out_valid, fill_mask, dup_err
  );
endinterface

// File: rtl/demux16_collector.sv
// Sequential 1-to-16 demultiplexer: steers tagged bits into a word and hands each
// completed word to a registered valid/ready output stage.
module demux16_collector #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  demux16_collector_if.slave  bus
);

  typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] asm_q, asm_n;
  logic [WIDTH-1:0] mask_q, mask_n;
  logic [WIDTH-1:0] word_q, word_n;
  logic             valid_q, valid_n;
  logic             dup_q, dup_n;

  logic [WIDTH-1:0] sel_bit;
  logic [WIDTH-1:0] merged;
  logic             hit;
  logic             accept;
  logic             slot_free;

  assign bus.in_ready  = (state_q == COLLECT) && !bus.clear;
  assign accept        = bus.in_valid && bus.in_ready;
  assign slot_free     = !valid_q || bus.out_ready;
  assign sel_bit       = WIDTH'(1) << bus.in_sel;
  assign hit           = |(mask_q & sel_bit);

  assign bus.out_word  = word_q;
  assign bus.out_valid = valid_q;
  assign bus.fill_mask = mask_q;
  assign bus.dup_err   = dup_q;

  always_comb begin
    merged = asm_q;
    merged[bus.in_sel] = bus.in_bit;
  end

  // The completing bit is folded in via 'merged' so the word leaves on the same edge.
  always_comb begin
    state_n = state_q;
    asm_n   = asm_q;
    mask_n  = mask_q;
    word_n  = word_q;
    valid_n = valid_q;
    dup_n   = 1'b0;

    if (valid_q && bus.out_ready) begin
      valid_n = 1'b0;
    end

    if (bus.clear) begin
      asm_n   = '0;
      mask_n  = '0;
      state_n = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (!hit && (&(mask_q | sel_bit))) begin
              if (slot_free) begin
                word_n  = merged;
                valid_n = 1'b1;
                asm_n   = '0;
                mask_n  = '0;
              end else begin
                asm_n   = merged;
                mask_n  = '1;
                state_n = HOLD;
              end
            end else begin
              asm_n  = merged;
              mask_n = mask_q | sel_bit;
              dup_n  = hit;
            end
          end
        end
        HOLD: begin
          // out_valid is always set here, so a drain reloads the slot without a bubble.
          if (valid_q && bus.out_ready) begin
            word_n  = asm_q;
            valid_n = 1'b1;
            asm_n   = '0;
            mask_n  = '0;
            state_n = COLLECT;
          end
        end
        default: state_n = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      asm_q   <= '0;
      mask_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      asm_q   <= asm_n;
      mask_q  <= mask_n;
      word_q  <= word_n;
      valid_q <= valid_n;
      dup_q   <= dup_n;
    end
  end

endmodule

// File: tb/tb_demux16_collector.sv
// Self-checking bench for demux16_collector: directed scenarios plus random traffic,
// all compared against a word-level reference model.
module tb_demux16_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  demux16_collector_if #(.WIDTH(16), .SEL_W(4)) ifc ();

  demux16_collector #(.WIDTH(16), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: partial word, pending output word, and a "full word waiting" flag.
  logic [15:0] m_asm, m_mask, m_word;
  bit          m_ov, m_dup, m_hold;
  bit          seen_ready, exp_ready;
  int          dup_count;

  task automatic model_reset();
    m_asm = '0; m_mask = '0; m_word = '0;
    m_ov = 0; m_dup = 0; m_hold = 0;
  endtask

  // Drives one cycle of inputs, samples in_ready before the edge and advances the model.
  task automatic apply_stimulus(input logic b, input logic [3:0] s, input logic v,
                                input logic c, input logic r);
    logic [15:0] pos;
    bit consumed, acc;
    ifc.in_bit = b; ifc.in_sel = s; ifc.in_valid = v; ifc.clear = c; ifc.out_ready = r;
    #1;
    seen_ready = ifc.in_ready;
    exp_ready  = !m_hold && !c;
    consumed   = m_ov && r;
    acc        = v && exp_ready;
    m_dup      = 0;
    if (c) begin
      m_asm = '0; m_mask = '0; m_hold = 0;
      if (consumed) m_ov = 0;
    end else if (m_hold) begin
      if (consumed) begin
        m_word = m_asm; m_asm = '0; m_mask = '0; m_hold = 0;
      end
    end else begin
      if (consumed) m_ov = 0;
      if (acc) begin
        pos    = 16'(1) << s;
        m_dup  = (m_mask & pos) != 0;
        m_asm  = b ? (m_asm | pos) : (m_asm & ~pos);
        m_mask = m_mask | pos;
        if (!m_dup && m_mask == 16'hFFFF) begin
          if (!m_ov) begin
            m_word = m_asm; m_ov = 1; m_asm = '0; m_mask = '0;
          end else begin
            m_hold = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (ifc.dup_err === 1'b1) dup_count++;
  endtask

  task automatic test_reset();
    ifc.in_bit = 0; ifc.in_sel = 0; ifc.in_valid = 0; ifc.clear = 0; ifc.out_ready = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ifc.out_valid, ifc.out_word, ifc.fill_mask, ifc.dup_err, ifc.in_ready} !== {1'b0, 16'h0, 16'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_state got ov=%b word=%h mask=%h dup=%b rdy=%b want 0/0000/0000/0/1",
               ifc.out_valid, ifc.out_word, ifc.fill_mask, ifc.dup_err, ifc.in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_in_order();
    logic [15:0] w;
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(w[i], 4'(i), 1'b1, 1'b0, 1'b1);
      checks++;
      if (seen_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL inorder_ready step=%0d got=%b want=1", i, seen_ready);
      end
      checks++;
      if ({ifc.out_valid, ifc.out_word, ifc.fill_mask, ifc.dup_err} !== {m_ov, m_word, m_mask, m_dup}) begin
        failures++;
        $display("[TB] FAIL inorder_state step=%0d got=%h want=%h", i,
                 {ifc.out_valid, ifc.out_word, ifc.fill_mask, ifc.dup_err}, {m_ov, m_word, m_mask, m_dup});
      end
    end
    checks++;
    if ({ifc.out_valid, ifc.out_word} !== {1'b1, 16'hA5C3}) begin
      failures++;
      $display("[TB] FAIL inorder_word got ov=%b word=%h want 1/a5c3", ifc.out_valid, ifc.out_word);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL inorder_drain got ov=%b want 0", ifc.out_valid);
    end
  endtask

  task automatic test_reverse_dup();
    logic [15:0] w;
    int dup_after;
    w = 16'h1234;
    dup_count = 0;
    dup_after = -1;
    for (int i = 15; i >= 8; i--) apply_stimulus(w[i], 4'(i), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
    apply_stimulus(w[7], 4'd7, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ifc.dup_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dup_pulse got=%b want=1", ifc.dup_err);
    end
    for (int i = 6; i >= 0; i--) begin
      apply_stimulus(w[i], 4'(i), 1'b1, 1'b0, 1'b1);
      if (i > 0) begin
        checks++;
        if (ifc.out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL dup_early_complete sel=%0d got ov=%b want 0", i, ifc.out_valid);
        end
      end
    end
    checks++;
    if ({ifc.out_valid, ifc.out_word, ifc.fill_mask} !== {1'b1, 16'h1234, 16'h0}) begin
      failures++;
      $display("[TB] FAIL reverse_word got ov=%b word=%h mask=%h want 1/1234/0000",
               ifc.out_valid, ifc.out_word, ifc.fill_mask);
    end
    checks++;
    if (dup_count !== 1) begin
      failures++;
      $display("[TB] FAIL dup_count got=%0d want=1", dup_count);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b;
    a = 16'h00FF; b = 16'hFF00;
    for (int i = 0; i < 16; i++) apply_stimulus(a[i], 4'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) apply_stimulus(b[i], 4'(i), 1'b1, 1'b0, 1'b0);
    checks++;
    if ({ifc.in_ready, ifc.fill_mask, ifc.out_valid, ifc.out_word} !== {1'b0, 16'hFFFF, 1'b1, 16'h00FF}) begin
      failures++;
      $display("[TB] FAIL hold_state got rdy=%b mask=%h ov=%b word=%h want 0/ffff/1/00ff",
               ifc.in_ready, ifc.fill_mask, ifc.out_valid, ifc.out_word);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({ifc.in_ready, ifc.fill_mask, ifc.out_valid, ifc.out_word} !== {1'b1, 16'h0, 1'b1, 16'hFF00}) begin
      failures++;
      $display("[TB] FAIL hold_drain got rdy=%b mask=%h ov=%b word=%h want 1/0000/1/ff00",
               ifc.in_ready, ifc.fill_mask, ifc.out_valid, ifc.out_word);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_clear();
    logic [15:0] a, w;
    int perm[16];
    a = 16'h5A5A;
    for (int i = 0; i < 16; i++) apply_stimulus(a[i], 4'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({seen_ready, ifc.fill_mask, ifc.out_valid, ifc.out_word, ifc.dup_err} !== {1'b0, 16'h0, 1'b1, 16'h5A5A, 1'b0}) begin
      failures++;
      $display("[TB] FAIL clear_abort got rdy=%b mask=%h ov=%b word=%h dup=%b want 0/0000/1/5a5a/0",
               seen_ready, ifc.fill_mask, ifc.out_valid, ifc.out_word, ifc.dup_err);
    end
    w = 16'($urandom);
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 16; i++) apply_stimulus(w[perm[i]], 4'(perm[i]), 1'b1, 1'b0, 1'b1);
    checks++;
    if ({ifc.out_valid, ifc.out_word} !== {1'b1, w}) begin
      failures++;
      $display("[TB] FAIL clear_refill got ov=%b word=%h want 1/%h", ifc.out_valid, ifc.out_word, w);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    ifc.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifc.out_valid, ifc.fill_mask, ifc.dup_err, ifc.in_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL async_reset got ov=%b mask=%h dup=%b rdy=%b want 0/0000/0/1",
               ifc.out_valid, ifc.fill_mask, ifc.dup_err, ifc.in_ready);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    w = 16'($urandom);
    for (int i = 0; i < 16; i++) apply_stimulus(w[i], 4'(i), 1'b1, 1'b0, 1'b1);
    checks++;
    if ({ifc.out_valid, ifc.out_word} !== {1'b1, w}) begin
      failures++;
      $display("[TB] FAIL reset_refill got ov=%b word=%h want 1/%h", ifc.out_valid, ifc.out_word, w);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    for (int n = 0; n < 3; n++) begin
      w = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        apply_stimulus(w[i], 4'(i), 1'b1, 1'b0, 1'b1);
        checks++;
        if (seen_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_bubble word=%0d step=%0d got rdy=%b want 1", n, i, seen_ready);
        end
      end
      checks++;
      if ({ifc.out_valid, ifc.out_word} !== {1'b1, w}) begin
        failures++;
        $display("[TB] FAIL b2b_word word=%0d got ov=%b word=%h want 1/%h", n, ifc.out_valid, ifc.out_word, w);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      apply_stimulus(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
      checks++;
      if (seen_ready !== exp_ready) begin
        failures++;
        $display("[TB] FAIL rand_ready cycle=%0d got=%b want=%b", n, seen_ready, exp_ready);
      end
      checks++;
      if ({ifc.out_valid, ifc.out_word, ifc.fill_mask, ifc.dup_err} !== {m_ov, m_word, m_mask, m_dup}) begin
        failures++;
        $display("[TB] FAIL rand_state cycle=%0d got=%h want=%h", n,
                 {ifc.out_valid, ifc.out_word, ifc.fill_mask, ifc.dup_err}, {m_ov, m_word, m_mask, m_dup});
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reverse_dup();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
